// File: rtl/md_sched.sv
// Multiply/divide scheduler: models the fixed latency of the MD unit, owns HI/LO,
// and requests a pipeline stall when stage D needs the unit while it is occupied.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [W-1:0]     hi_n, lo_n, hi_n_nxt, lo_n_nxt;
    logic [W-1:0]     hi_nxt, lo_nxt;

    logic             op_md;
    logic [2*W-1:0]   prod_s, prod_u;
    logic             div_signed, b_zero, neg_q, neg_r;
    logic [W-1:0]     a_mag, b_mag, q_mag, r_mag, quot, rem;

    // Multiply: low 64 bits of the sign-/zero-extended product
    always_comb begin
        prod_s = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end

    // Divide on magnitudes, then restore signs; this also keeps 0x80000000 / -1
    // well defined (quotient wraps to 0x80000000, remainder 0).
    always_comb begin
        div_signed = (op == OP_DIV);
        b_zero     = (b == '0);
        a_mag      = (div_signed && a[W-1]) ? (~a + W'(1)) : a;
        b_mag      = (div_signed && b[W-1]) ? (~b + W'(1)) : b;
        q_mag      = b_zero ? '0 : (a_mag / b_mag);
        r_mag      = b_zero ? '0 : (a_mag % b_mag);
        neg_q      = div_signed && (a[W-1] ^ b[W-1]);
        neg_r      = div_signed && a[W-1];
        quot       = neg_q ? (~q_mag + W'(1)) : q_mag;
        rem        = neg_r ? (~r_mag + W'(1)) : r_mag;
    end

    assign op_md = (op <= OP_DIVU);

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        hi_n_nxt  = hi_n;
        lo_n_nxt  = lo_n;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {hi_n_nxt, lo_n_nxt} = prod_s;
                            cnt_nxt              = CNT_W'(MULT_CYCLES);
                            state_nxt            = RUN;
                        end
                        OP_MULTU: begin
                            {hi_n_nxt, lo_n_nxt} = prod_u;
                            cnt_nxt              = CNT_W'(MULT_CYCLES);
                            state_nxt            = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still occupies the unit but commits the old HI/LO
                            hi_n_nxt  = b_zero ? hi : rem;
                            lo_n_nxt  = b_zero ? lo : quot;
                            cnt_nxt   = CNT_W'(DIV_CYCLES);
                            state_nxt = RUN;
                        end
                        OP_MTHI: hi_nxt = a;
                        OP_MTLO: lo_nxt = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    hi_nxt    = hi_n;
                    lo_nxt    = lo_n;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            hi_n  <= '0;
            lo_n  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            hi_n  <= hi_n_nxt;
            lo_n  <= lo_n_nxt;
        end
    end

    assign busy  = (state == RUN);
    assign stall = md_use_D & (busy | (start & op_md));

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: vector table with a result scoreboard,
// plus hand-written no-op and mid-run reset sequences.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset, start, md_use_D;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, stall;

    always #5 clk = ~clk;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .md_use_D (md_use_D),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_d;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int unsigned n;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned n;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[12];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // The pipeline never issues while the unit is busy
    always @(posedge clk) begin
        if (reset === 1'b0 && busy === 1'b1 && start === 1'b1) begin
            total++;
            bad++;
            $display("FAIL start_in_run: start=1 while busy=1 (t=%0t)", $time);
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        int unsigned n;
        logic [31:0] ph, pl;
        ph       = hi;
        pl       = lo;
        start    = 1'b1;
        op       = v.op;
        a        = v.a;
        b        = v.b;
        md_use_D = v.use_d;
        #1;
        chk($sformatf("stall_issue[%0d]", idx), 32'(stall), 32'(v.use_d && (v.op <= 3'd3)));
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        e.hi  = v.exp_hi;
        e.lo  = v.exp_lo;
        e.n   = v.n;
        sbq.push_back(e);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            chk($sformatf("hold_hi[%0d]", idx), hi, ph);
            chk($sformatf("hold_lo[%0d]", idx), lo, pl);
            chk($sformatf("stall_busy[%0d]", idx), 32'(stall), 32'(v.use_d));
            tick();
        end
        e = sbq.pop_front();
        chk($sformatf("busy_cycles[%0d]", idx), 32'(n), 32'(e.n));
        chk($sformatf("hi[%0d]", idx), hi, e.hi);
        chk($sformatf("lo[%0d]", idx), lo, e.lo);
        chk($sformatf("stall_after[%0d]", idx), 32'(stall), 32'd0);
        md_use_D = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ph, pl;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd7,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,         1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2]  = '{3'd3, 32'd100,       32'd7,         1'b0, 32'd2,         32'd14,        10};
        vecs[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5]  = '{3'd4, 32'h0000_1234, 32'd0,         1'b0, 32'h0000_1234, 32'h8000_0000, 0};
        vecs[6]  = '{3'd5, 32'h0000_5678, 32'd0,         1'b0, 32'h0000_1234, 32'h0000_5678, 0};
        vecs[7]  = '{3'd2, 32'd5,         32'd0,         1'b0, 32'h0000_1234, 32'h0000_5678, 10};
        vecs[8]  = '{3'd0, 32'd3,         32'd4,         1'b1, 32'h0000_0000, 32'h0000_000C, 5};
        vecs[9]  = '{3'd3, 32'd7,         32'hFFFF_FFFF, 1'b0, 32'h0000_0007, 32'h0000_0000, 10};
        vecs[10] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[11] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, 5};

        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd7;
        a        = '0;
        b        = '0;
        md_use_D = 1'b0;
        tick();
        tick();
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // No-op encoding: no stall, no state change
        ph       = hi;
        pl       = lo;
        start    = 1'b1;
        op       = 3'd6;
        a        = 32'hDEAD_BEEF;
        md_use_D = 1'b1;
        #1;
        chk("noop_stall", 32'(stall), 32'd0);
        tick();
        start    = 1'b0;
        md_use_D = 1'b0;
        chk("noop_busy", 32'(busy), 32'd0);
        chk("noop_hi", hi, ph);
        chk("noop_lo", lo, pl);

        // Reset during the third busy cycle of a divide discards the result
        start = 1'b1;
        op    = 3'd3;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        start = 1'b0;
        chk("rst_run_busy1", 32'(busy), 32'd1);
        tick();
        tick();
        chk("rst_run_busy3", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        chk("rst_run_hi", hi, 32'd0);
        chk("rst_run_lo", lo, 32'd0);
        chk("rst_run_busy", 32'(busy), 32'd0);
        start    = 1'b1;
        op       = 3'd0;
        md_use_D = 1'b1;
        #1;
        chk("rst_stall_start", 32'(stall), 32'd1);
        start = 1'b0;
        #1;
        chk("rst_stall_idle", 32'(stall), 32'd0);
        md_use_D = 1'b0;
        reset    = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("post_rst_hi[%0d]", k), hi, 32'd0);
            chk($sformatf("post_rst_lo[%0d]", k), lo, 32'd0);
            chk($sformatf("post_rst_busy[%0d]", k), 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
